bomb_controller: RTL and testbench
==================================

Name: bomb_controller

Overview:
- Game-level sequencer that sits directly downstream of the countdown timer and consumes its secLeft output.
- Drives the timer's set/sec load interface.
- Gathers strike pulses and solved levels from the puzzle modules.
- Decides armed / defused / exploded, applies time penalties on strikes, and emits a once-per-second tick for the buzzer.

Parameters:
START_SEC, 300, seconds loaded at arm time (16-bit)
NUM_MODULES, 5, number of puzzle modules
MAX_STRIKES, 3, strike count that detonates (1..3)
STRIKE_PENALTY, 15, seconds removed per non-fatal strike

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  arm request, sampled per cycle
strike  in  NUM_MODULES  one-cycle strike pulses, one bit per module
solved  in  NUM_MODULES  level, high once the module is solved
secLeft  in  16  seconds remaining from the timer
timer_set  out  1  load strobe/hold to the timer
timer_sec  out  16  value loaded into the timer
strikes  out  2  strikes accumulated
armed  out  1  high in ARMED
defused  out  1  high in DEFUSED
exploded  out  1  high in EXPLODED
tick  out  1  one-cycle pulse per secLeft decrement while armed

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, timer_set=0, timer_sec=0, strikes=0, armed=defused=exploded=tick=0.
- Reset asserted mid-operation: all outputs return to reset values at the next edge; no other input is honoured that cycle.
- States: IDLE, LOAD, SETTLE, ARMED, PENALTY, DEFUSED, EXPLODED.
- IDLE
  - timer_set=1, timer_sec=START_SEC, held so the display shows the start value.
  - start=1 -> LOAD.
- LOAD
  - timer_set=1, timer_sec=START_SEC for exactly one cycle; strikes cleared to 0.
  - -> SETTLE.
- SETTLE
  - timer_set=0. secLeft now reflects the loaded value; it is captured into prev_sec.
  - -> ARMED.
- ARMED
  - armed=1, timer_set=0.
  - Evaluated each cycle, first match wins:
    1. solved all ones -> DEFUSED. Solve beats a simultaneous strike or zero; strikes is unchanged.
    2. Any strike bit high -> counts as exactly one strike regardless of how many bits are set. strikes+1.
       - New count == MAX_STRIKES -> EXPLODED.
       - Otherwise -> PENALTY.
    3. secLeft==0 -> EXPLODED.
  - tick=1 for one cycle when secLeft != prev_sec; prev_sec is updated every cycle.
- PENALTY
  - One cycle: timer_set=1.
  - timer_sec = secLeft-STRIKE_PENALTY if secLeft>STRIKE_PENALTY, else 0 (saturating, no wrap).
  - Strikes arriving in PENALTY or SETTLE are ignored.
  - -> SETTLE.
- DEFUSED
  - defused=1, timer_set held 1, timer_sec = secLeft captured on entry, so the timer display freezes.
- EXPLODED
  - exploded=1, timer_set held 1, timer_sec=0.
- DEFUSED and EXPLODED are terminal.
  - start=1 -> LOAD; strikes cleared in LOAD; flags drop on leaving.
- tick is never asserted outside ARMED. No spurious tick on ARMED entry, because prev_sec is refreshed in SETTLE.
- The timer restarts its sub-second counter on every set; the resulting up-to-1 s lengthening per penalty is accepted.
- armed, defused and exploded are mutually exclusive (one-hot or all zero).

Test Plan:
1. Reset, start pulse -> timer_set high for 1 cycle with timer_sec=300 -> armed=1 two edges after start is sampled; secLeft=300; tick=0 on entry.
2. ARMED with secLeft=100, strike=5'b00100 for 1 cycle -> strikes=1, one timer_set pulse with timer_sec=85, back in ARMED with secLeft=85.
3. ARMED with secLeft=10, single strike -> timer_sec=0 (saturated) -> next ARMED cycle sees secLeft=0 -> exploded=1, strikes=1, timer_sec=0 held.
4. Three separate strikes; second strike overlaps with strike=5'b11000 in the same cycle -> counted as one. Third strike -> exploded=1, strikes=3, no PENALTY pulse.
5. solved=5'b11111 together with a strike pulse at secLeft=42 -> defused=1, strikes unchanged, timer_set held with timer_sec=42; start afterwards re-arms to 300 with strikes=0.
6. Reset asserted mid-ARMED (secLeft=120, strikes=2) -> next edge all outputs at reset values, state IDLE. Separately, let a decrement 300->299 occur during ARMED -> exactly one tick pulse.

Source files
------------

// File: rtl/bomb_controller.sv
// Game-level sequencer for the bomb: arms the countdown timer, tracks strikes and solved modules,
// and decides defused/exploded. All outputs are registered from the next-state decode.
module bomb_controller #(
  parameter logic [15:0] START_SEC      = 16'd300,
  parameter int          NUM_MODULES    = 5,
  parameter int          MAX_STRIKES    = 3,
  parameter logic [15:0] STRIKE_PENALTY = 16'd15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_MODULES-1:0] strike,
  input  logic [NUM_MODULES-1:0] solved,
  input  logic [15:0]            secLeft,
  output logic                   timer_set,
  output logic [15:0]            timer_sec,
  output logic [1:0]             strikes,
  output logic                   armed,
  output logic                   defused,
  output logic                   exploded,
  output logic                   tick
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SETTLE   = 3'd2;
  localparam logic [2:0] ARMED    = 3'd3;
  localparam logic [2:0] PENALTY  = 3'd4;
  localparam logic [2:0] DEFUSED  = 3'd5;
  localparam logic [2:0] EXPLODED = 3'd6;

  localparam logic [1:0] MAX_STK = 2'(MAX_STRIKES);

  logic [2:0]  state_r;
  logic [2:0]  next_s;
  logic [15:0] prev_sec_r;
  logic [1:0]  strikes_inc_s;
  logic        strike_any_s;
  logic        all_solved_s;
  logic        strike_hit_s;

  // Time remaining after a penalty, clamped at zero instead of wrapping.
  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    if (a > b) begin
      sat_sub = a - b;
    end else begin
      sat_sub = 16'd0;
    end
  endfunction

  assign strike_any_s  = |strike;
  assign all_solved_s  = &solved;
  assign strikes_inc_s = strikes + 2'd1;
  // A solve in the same cycle overrides any strike.
  assign strike_hit_s  = (state_r == ARMED) && !all_solved_s && strike_any_s;

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = LOAD;
        else       next_s = IDLE;
      end
      LOAD:    next_s = SETTLE;
      SETTLE:  next_s = ARMED;
      ARMED: begin
        if (all_solved_s) begin
          next_s = DEFUSED;
        end else if (strike_any_s) begin
          if (strikes_inc_s == MAX_STK) next_s = EXPLODED;
          else                          next_s = PENALTY;
        end else if (secLeft == 16'd0) begin
          next_s = EXPLODED;
        end else begin
          next_s = ARMED;
        end
      end
      PENALTY: next_s = SETTLE;
      DEFUSED, EXPLODED: begin
        if (start) next_s = LOAD;
        else       next_s = state_r;
      end
      default: next_s = IDLE;
    endcase
  end

  // State, strike counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      prev_sec_r <= 16'd0;
      timer_set  <= 1'b0;
      timer_sec  <= 16'd0;
      strikes    <= 2'd0;
      armed      <= 1'b0;
      defused    <= 1'b0;
      exploded   <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state_r    <= next_s;
      prev_sec_r <= secLeft;
      armed      <= (next_s == ARMED);
      defused    <= (next_s == DEFUSED);
      exploded   <= (next_s == EXPLODED);
      // Only ticks while staying armed, so tick never overlaps another state.
      tick       <= (state_r == ARMED) && (next_s == ARMED) && (secLeft != prev_sec_r);

      if (strike_hit_s) begin
        strikes <= strikes_inc_s;
      end else if (next_s == LOAD) begin
        strikes <= 2'd0;
      end

      case (next_s)
        IDLE, LOAD: begin
          timer_set <= 1'b1;
          timer_sec <= START_SEC;
        end
        SETTLE, ARMED: begin
          timer_set <= 1'b0;
        end
        PENALTY: begin
          timer_set <= 1'b1;
          timer_sec <= sat_sub(secLeft, STRIKE_PENALTY);
        end
        DEFUSED: begin
          timer_set <= 1'b1;
          // Freeze the display on the value seen at entry.
          if (state_r != DEFUSED) timer_sec <= secLeft;
        end
        EXPLODED: begin
          timer_set <= 1'b1;
          timer_sec <= 16'd0;
        end
        default: begin
          timer_set <= 1'b0;
          timer_sec <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_controller.sv
// Scoreboard bench for bomb_controller: stimulus pushes expected output snapshots tagged
// with the cycle they are due; a monitor pops and compares them on the falling edge.
module tb_bomb_controller;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  strike, solved;
  logic [15:0] secLeft;
  logic        timer_set;
  logic [15:0] timer_sec;
  logic [1:0]  strikes;
  logic        armed, defused, exploded, tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    int          due;
    logic        ts;
    logic [15:0] sec;
    bit          chk_sec;
    logic [1:0]  stk;
    logic [3:0]  flags;  // {armed, defused, exploded, tick}
  } exp_t;

  exp_t q[$];

  bomb_controller #(
    .START_SEC(16'd300), .NUM_MODULES(5), .MAX_STRIKES(3), .STRIKE_PENALTY(16'd15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .strike(strike), .solved(solved),
    .secLeft(secLeft), .timer_set(timer_set), .timer_sec(timer_sec), .strikes(strikes),
    .armed(armed), .defused(defused), .exploded(exploded), .tick(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Queue the expected outputs after the next edge, then advance one cycle.
  task automatic ex(input string n, input logic ts, input logic [15:0] sec, input bit cs,
                    input logic [1:0] stk, input logic [3:0] flags);
    exp_t e;
    e.name = n; e.due = cyc + 1; e.ts = ts; e.sec = sec; e.chk_sec = cs;
    e.stk = stk; e.flags = flags;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every snapshot that falls due this cycle.
  initial begin
    exp_t e;
    logic [3:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e   = q.pop_front();
        got = {armed, defused, exploded, tick};
        checks++;
        if (e.due != cyc || timer_set !== e.ts || strikes !== e.stk || got !== e.flags ||
            (e.chk_sec && timer_sec !== e.sec)) begin
          errors++;
          $display("FAIL %s cyc=%0d got set=%0b sec=%0d stk=%0d adet=%04b want set=%0b sec=%0d(chk=%0b) stk=%0d adet=%04b",
                   e.name, cyc, timer_set, timer_sec, strikes, got,
                   e.ts, e.sec, e.chk_sec, e.stk, e.flags);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; strike = 5'd0; solved = 5'd0; secLeft = 16'd0;
    ex("reset", 1'b0, 16'd0, 1'b1, 2'd0, 4'b0000);
    reset = 1'b0;
    ex("idle", 1'b1, 16'd300, 1'b1, 2'd0, 4'b0000);

    // Arm: LOAD strobe, SETTLE, ARMED two edges after start is sampled
    start = 1'b1;
    ex("t1_load", 1'b1, 16'd300, 1'b1, 2'd0, 4'b0000);
    start = 1'b0; secLeft = 16'd300;
    ex("t1_settle", 1'b0, 16'd0, 1'b0, 2'd0, 4'b0000);
    ex("t1_armed", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1000);
    ex("t1_no_tick", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1000);

    // One decrement gives exactly one tick
    secLeft = 16'd299;
    ex("t6_tick", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1001);
    ex("t6_tick_once", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1000);

    // Non-fatal strike at 100 -> penalty load of 85
    secLeft = 16'd100;
    ex("t2_pre", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1001);
    strike = 5'b00100;
    ex("t2_penalty", 1'b1, 16'd85, 1'b1, 2'd1, 4'b0000);
    strike = 5'd0; secLeft = 16'd85;
    ex("t2_settle", 1'b0, 16'd0, 1'b0, 2'd1, 4'b0000);
    ex("t2_rearmed", 1'b0, 16'd0, 1'b0, 2'd1, 4'b1000);

    // Second strike, then reset mid-ARMED with competing inputs
    strike = 5'b00001;
    ex("a_penalty2", 1'b1, 16'd70, 1'b1, 2'd2, 4'b0000);
    strike = 5'd0; secLeft = 16'd70;
    ex("a_settle2", 1'b0, 16'd0, 1'b0, 2'd2, 4'b0000);
    ex("a_armed2", 1'b0, 16'd0, 1'b0, 2'd2, 4'b1000);
    secLeft = 16'd120;
    ex("a_armed120", 1'b0, 16'd0, 1'b0, 2'd2, 4'b1001);
    reset = 1'b1; start = 1'b1; strike = 5'b00001; solved = 5'b11111;
    ex("t6_reset", 1'b0, 16'd0, 1'b1, 2'd0, 4'b0000);
    reset = 1'b0; start = 1'b0; strike = 5'd0; solved = 5'd0;
    ex("t6_idle", 1'b1, 16'd300, 1'b1, 2'd0, 4'b0000);

    // Saturating penalty at 10 s, then zero explodes
    start = 1'b1;
    ex("b_load", 1'b1, 16'd300, 1'b1, 2'd0, 4'b0000);
    start = 1'b0; secLeft = 16'd300;
    ex("b_settle", 1'b0, 16'd0, 1'b0, 2'd0, 4'b0000);
    ex("b_armed", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1000);
    secLeft = 16'd10;
    ex("b_tick", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1001);
    strike = 5'b00001;
    ex("t3_penalty", 1'b1, 16'd0, 1'b1, 2'd1, 4'b0000);
    strike = 5'd0; secLeft = 16'd0;
    ex("t3_settle", 1'b0, 16'd0, 1'b0, 2'd1, 4'b0000);
    ex("t3_armed", 1'b0, 16'd0, 1'b0, 2'd1, 4'b1000);
    ex("t3_exploded", 1'b1, 16'd0, 1'b1, 2'd1, 4'b0010);
    ex("t3_hold", 1'b1, 16'd0, 1'b1, 2'd1, 4'b0010);

    // Three strikes, multi-bit strike counts once, third detonates with no penalty
    start = 1'b1;
    ex("c_load", 1'b1, 16'd300, 1'b1, 2'd0, 4'b0000);
    start = 1'b0; secLeft = 16'd300;
    ex("c_settle", 1'b0, 16'd0, 1'b0, 2'd0, 4'b0000);
    ex("c_armed", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1000);
    strike = 5'b00001;
    ex("t4_s1", 1'b1, 16'd285, 1'b1, 2'd1, 4'b0000);
    strike = 5'd0; secLeft = 16'd285;
    ex("t4_settle1", 1'b0, 16'd0, 1'b0, 2'd1, 4'b0000);
    ex("t4_armed1", 1'b0, 16'd0, 1'b0, 2'd1, 4'b1000);
    strike = 5'b11000;
    ex("t4_s2", 1'b1, 16'd270, 1'b1, 2'd2, 4'b0000);
    strike = 5'd0; secLeft = 16'd270;
    ex("t4_settle2", 1'b0, 16'd0, 1'b0, 2'd2, 4'b0000);
    ex("t4_armed2", 1'b0, 16'd0, 1'b0, 2'd2, 4'b1000);
    strike = 5'b00010;
    ex("t4_s3", 1'b1, 16'd0, 1'b1, 2'd3, 4'b0010);
    strike = 5'd0;
    ex("t4_hold", 1'b1, 16'd0, 1'b1, 2'd3, 4'b0010);

    // Solve beats a simultaneous strike; display freezes at 42; start re-arms
    start = 1'b1;
    ex("d_load", 1'b1, 16'd300, 1'b1, 2'd0, 4'b0000);
    start = 1'b0; secLeft = 16'd42;
    ex("d_settle", 1'b0, 16'd0, 1'b0, 2'd0, 4'b0000);
    ex("d_armed", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1000);
    solved = 5'b11111; strike = 5'b00001;
    ex("t5_defused", 1'b1, 16'd42, 1'b1, 2'd0, 4'b0100);
    strike = 5'd0; secLeft = 16'd41;
    ex("t5_frozen", 1'b1, 16'd42, 1'b1, 2'd0, 4'b0100);
    start = 1'b1;
    ex("t5_load", 1'b1, 16'd300, 1'b1, 2'd0, 4'b0000);
    start = 1'b0; solved = 5'd0; secLeft = 16'd300;
    ex("t5_settle", 1'b0, 16'd0, 1'b0, 2'd0, 4'b0000);
    ex("t5_armed", 1'b0, 16'd0, 1'b0, 2'd0, 4'b1000);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending got %0d unchecked entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
